// File: rtl/noc_rst_seq.sv
// Multi-channel NoC reset sequencer: staggered power-on release, then per-channel
// isolate/drain/reset/release handshakes. Optional drain timeout: NOC_RST_TIMEOUT_EN.
module noc_rst_seq #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int HOLD_CYC  = 4,
  parameter int DRAIN_MAX = 200
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CNT_W-1:0]  gap_i,
  input  logic [NUM_CH-1:0] sw_rst_req_i,
  input  logic [NUM_CH-1:0] idle_i,
  output logic [NUM_CH-1:0] isolate_o,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic [NUM_CH-1:0] sw_rst_ack_o,
  output logic              seq_done_o,
  output logic [NUM_CH-1:0] timeout_o
);

  localparam int               IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

  typedef enum logic {G_SEQ, G_DONE} g_st_t;
  typedef enum logic [2:0] {C_RST, C_RUN, C_ISO, C_DRAIN, C_HOLD, C_REL} ch_st_t;

  g_st_t             r_g, w_g_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_gcnt, w_gcnt_nxt;
  logic [CNT_W-1:0]  r_gap, w_gap;
  logic              r_gap_ld;
  logic              r_seq_done;
  logic [NUM_CH-1:0] w_rel;

  ch_st_t            r_st     [NUM_CH];
  ch_st_t            w_st_nxt [NUM_CH];
  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt[NUM_CH];

`ifdef NOC_RST_TIMEOUT_EN
  logic [NUM_CH-1:0] w_to_set;
  logic [NUM_CH-1:0] r_timeout;
`endif

  // Global power-on sequencer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_g        <= G_SEQ;
      r_idx      <= '0;
      r_gcnt     <= '0;
      r_gap_ld   <= 1'b0;
      r_seq_done <= 1'b0;
    end else begin
      r_g        <= w_g_nxt;
      r_idx      <= w_idx_nxt;
      r_gcnt     <= w_gcnt_nxt;
      r_seq_done <= (r_g == G_DONE);
      if (!r_gap_ld) begin
        r_gap    <= gap_i;
        r_gap_ld <= 1'b1;
      end
    end
  end

  // The first SEQ cycle must already reload with the live gap value
  assign w_gap = r_gap_ld ? r_gap : gap_i;

  always_comb begin
    w_g_nxt    = r_g;
    w_idx_nxt  = r_idx;
    w_gcnt_nxt = r_gcnt;
    w_rel      = '0;
    if (r_g == G_SEQ) begin
      if (r_gcnt == '0) begin
        for (int k = 0; k < NUM_CH; k++)
          if (r_idx == IDX_W'(k)) w_rel[k] = 1'b1;
        w_gcnt_nxt = w_gap;
        if (r_idx == IDX_LAST) w_g_nxt = G_DONE;
        else                   w_idx_nxt = r_idx + 1'b1;
      end else begin
        w_gcnt_nxt = r_gcnt - 1'b1;
      end
    end
  end

  // Per-channel software reset handshakes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_st[k]  <= C_RST;
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_st[k]  <= w_st_nxt[k];
        r_cnt[k] <= w_cnt_nxt[k];
      end
    end
  end

  always_comb begin
`ifdef NOC_RST_TIMEOUT_EN
    w_to_set = '0;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      w_st_nxt[k]  = r_st[k];
      w_cnt_nxt[k] = r_cnt[k];
      case (r_st[k])
        C_RST:   if (w_rel[k]) w_st_nxt[k] = C_RUN;
        C_RUN:   if (r_g == G_DONE && sw_rst_req_i[k]) w_st_nxt[k] = C_ISO;
        C_ISO: begin
          w_st_nxt[k]  = C_DRAIN;
          w_cnt_nxt[k] = '0;
        end
        C_DRAIN: begin
          if (idle_i[k]) begin
            w_st_nxt[k]  = C_HOLD;
            w_cnt_nxt[k] = '0;
          end else if (r_cnt[k] == DRAIN_LAST) begin
            // Counter parks at the threshold; with the timeout build it forces the reset
`ifdef NOC_RST_TIMEOUT_EN
            w_st_nxt[k]  = C_HOLD;
            w_cnt_nxt[k] = '0;
            w_to_set[k]  = 1'b1;
`endif
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + 1'b1;
          end
        end
        C_HOLD: begin
          if (r_cnt[k] == HOLD_LAST) w_st_nxt[k] = C_REL;
          else                       w_cnt_nxt[k] = r_cnt[k] + 1'b1;
        end
        C_REL:   w_st_nxt[k] = C_RUN;
        default: w_st_nxt[k] = C_RST;
      endcase
    end
  end

  always_comb begin
    isolate_o    = '0;
    ch_rst_o     = '0;
    sw_rst_ack_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      isolate_o[k]    = (r_st[k] != C_RUN);
      ch_rst_o[k]     = (r_st[k] == C_RST) || (r_st[k] == C_HOLD);
      sw_rst_ack_o[k] = (r_st[k] == C_REL);
    end
  end

  assign seq_done_o = r_seq_done;

`ifdef NOC_RST_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) r_timeout <= '0;
    else       r_timeout <= r_timeout | w_to_set;
  end
  assign timeout_o = r_timeout;
`else
  assign timeout_o = '0;
`endif

endmodule

// File: doc/noc_rst_seq.md
Name: noc_rst_seq

Overview:
- Multi-channel reset sequencer for the AXI NoC crossbar ports; sits between the system reset and the per-port reset and isolation inputs of the xbar and its endpoints.
- On global reset, releases the channel resets in ascending order with a programmable gap between channels.
- At run time, performs per-channel software resets with an isolate -> drain -> reset -> release handshake, so a port is never reset with AXI transactions outstanding.

Parameters:
- NUM_CH, 4, number of reset channels (1..16).
- CNT_W, 8, width of the gap, drain and hold counters.
- HOLD_CYC, 4, cycles ch_rst_o stays asserted during a software reset (1..2^CNT_W-1).
- DRAIN_MAX, 200, drain timeout in cycles; used only with NOC_RST_TIMEOUT_EN (1..2^CNT_W-1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- gap_i  in  CNT_W  cycles between successive channel releases during power-on sequencing; sampled when SEQ is entered.
- sw_rst_req_i  in  NUM_CH  per-channel software reset request; level.
- idle_i  in  NUM_CH  per-channel no-outstanding-AXI indication from the port.
- isolate_o  out  NUM_CH  per-channel isolation; the port must stop accepting new AW/AR.
- ch_rst_o  out  NUM_CH  per-channel reset to the port, active-high.
- sw_rst_ack_o  out  NUM_CH  one-cycle pulse when a channel's software reset completes.
- seq_done_o  out  1  high once all channels have been released after rst_i.
- timeout_o  out  NUM_CH  sticky drain-timeout flag per channel.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values (rst_i=1):
  - ch_rst_o and isolate_o all ones.
  - sw_rst_ack_o, seq_done_o and timeout_o all zero.
  - Global FSM = SEQ; channel index = 0; gap counter = 0.
- Global FSM, SEQ state:
  - gap_i is latched into the gap register on the first SEQ cycle after rst_i deasserts.
  - Channel 0 is released on that first cycle: ch_rst_o[0]=0 and isolate_o[0]=0 on the same edge.
  - Each subsequent channel k is released exactly G+1 cycles after channel k-1, where G is the latched gap.
  - gap_i=0 releases one channel per cycle.
  - After the last channel is released, the FSM goes to DONE and seq_done_o=1 on the next cycle.
  - sw_rst_req_i is ignored while in SEQ.
- Global FSM, DONE state: terminal until rst_i.
- Per-channel FSM (active only in DONE): RUN -> ISO -> DRAIN -> HOLD -> REL -> RUN.
  - RUN: isolate_o=0, ch_rst_o=0. sw_rst_req_i=1 -> ISO.
  - ISO: isolate_o=1 for exactly one cycle before DRAIN, so the port sees isolation before idle is sampled.
  - DRAIN: isolate_o=1; drain counter increments each cycle. idle_i=1 -> HOLD.
  - HOLD: ch_rst_o=1 for HOLD_CYC cycles, then -> REL.
  - REL: ch_rst_o=0, isolate_o stays 1 for one cycle; sw_rst_ack_o pulses; -> RUN (isolate_o=0).
- Request handling:
  - A request held high after the ack starts a new sequence, re-entering ISO the cycle after returning to RUN.
  - Deasserting sw_rst_req_i after ISO does not abort the sequence.
- Channels are independent: simultaneous requests on any subset proceed in parallel with no arbitration.
- rst_i mid-operation: all channels return to reset values immediately; any in-flight acks are dropped; the power-on sequence restarts.
- Counters saturate and never wrap. If idle_i never rises without the optional feature, the channel stays in DRAIN indefinitely.

Optional Feature:
- NOC_RST_TIMEOUT_EN
- Defined:
  - In DRAIN, if the drain counter reaches DRAIN_MAX with idle_i still 0, the channel goes to HOLD anyway.
  - timeout_o[ch] is set and held until rst_i. It is not cleared by a later successful sequence.
- Undefined: no timeout; timeout_o tied to zero; DRAIN_MAX unused.

Test Plan:
- Power-on sequencing: NUM_CH=4, gap_i=3, rst_i high 5 cycles then low.
  - ch_rst_o[0..3] fall at cycles 1, 5, 9 and 13 after release.
  - seq_done_o rises at cycle 14.
- Zero gap: gap_i=0 -> the four channels release on consecutive cycles; seq_done_o high at cycle 5.
- Software reset, channel 2: pulse sw_rst_req_i[2] with idle_i[2] rising 10 cycles after isolate_o[2].
  - ch_rst_o[2] high for exactly 4 cycles; single-cycle sw_rst_ack_o[2].
  - Other channels undisturbed.
- Simultaneous requests: sw_rst_req_i=4'b1011 with all idle_i=1 -> three channels complete in parallel, each ack 1+1+4+1 cycles after its request.
- Timeout (macro defined): idle_i[1]=0 forever.
  - After 200 DRAIN cycles, ch_rst_o[1] asserts and timeout_o[1]=1 (sticky).
  - Without the macro, the channel stays in DRAIN for 1000 cycles and timeout_o=0.
- Mid-operation reset: assert rst_i while channel 0 is in HOLD -> all outputs at reset values next cycle, no ack, sequencing restarts.
